// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, word/round-key types and the
// unexpander state encoding. Also used by the forward key expansion.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT14,
    ST_EMIT13,
    ST_EXPAND,
    ST_FINISH
  } state_t;

  // Indexed by i/8 for key-schedule word i; entry 0 is never used.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: the S-box applied to each byte of a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = {sbox_byte(x[31:24]), sbox_byte(x[23:16]),
              sbox_byte(x[15:8]),  sbox_byte(x[7:0])};

endmodule

// File: rtl/aes256_key_unexpand.sv
// Reverse AES-256 key schedule: from RK13/RK14 regenerate RK14..RK0 one word
// per cycle through an 8-word sliding window, then report the cipher key.
module aes256_key_unexpand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] last_keys,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done,
  output logic [255:0] cipher_key
);

  localparam logic [5:0] STEP_FIRST = 6'(4 * (NUM_ROUNDS + 1) - 1);

  state_t      state;
  word_t       win [8];
  logic [5:0]  step;
  logic [5:0]  step_m8;
  word_t       sub_in;
  word_t       sub_out;
  word_t       f_val;
  word_t       new_w;
  logic        beat;
  logic        stall;

  // Handshake: a beat transfers on the edge where rk_valid && rk_ready; while
  // rk_valid && !rk_ready, rk_data/rk_idx hold and the schedule does not step.
  assign beat  = rk_valid && rk_ready;
  assign stall = rk_valid && !rk_ready;

  // win[0] is the oldest word w[i-7], win[7] is w[i]; win[6] feeds f().
  always_comb begin
    sub_in = win[6];
    if (step[2:0] == 3'd0) sub_in = {win[6][23:0], win[6][31:24]};
  end

  aes_subword u_subword (
    .x (sub_in),
    .y (sub_out)
  );

  always_comb begin
    f_val = win[6];
    if (step[2:0] == 3'd0)      f_val = sub_out ^ {RCON[step[5:3]], 24'h0};
    else if (step[2:0] == 3'd4) f_val = sub_out;
  end

  assign new_w   = win[7] ^ f_val;
  assign step_m8 = step - 6'd8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      step       <= '0;
      rk_valid   <= 1'b0;
      rk_data    <= '0;
      rk_idx     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cipher_key <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < 8; k++) win[k] <= last_keys[255-32*k -: 32];
            step     <= STEP_FIRST;
            rk_valid <= 1'b1;
            rk_data  <= last_keys[127:0];
            rk_idx   <= 4'(NUM_ROUNDS);
            busy     <= 1'b1;
            state    <= ST_EMIT14;
          end
        end
        ST_EMIT14: begin
          if (beat) begin
            rk_data <= {win[0], win[1], win[2], win[3]};
            rk_idx  <= 4'(NUM_ROUNDS - 1);
            state   <= ST_EMIT13;
          end
        end
        ST_EMIT13: begin
          if (beat) begin
            rk_valid <= 1'b0;
            state    <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (!stall) begin
            win[0] <= new_w;
            for (int k = 7; k > 0; k--) win[k] <= win[k-1];
            step <= step - 6'd1;
            // w[i-8] starts a round key when i is a multiple of 4.
            if (step[1:0] == 2'b00) begin
              rk_valid <= 1'b1;
              rk_data  <= {new_w, win[0], win[1], win[2]};
              rk_idx   <= step_m8[5:2];
            end else if (beat) begin
              rk_valid <= 1'b0;
            end
            if (step == 6'd8) state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (beat) begin
            rk_valid   <= 1'b0;
            cipher_key <= {win[0], win[1], win[2], win[3],
                           win[4], win[5], win[6], win[7]};
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_unexpand.sv
// Bench for aes256_key_unexpand: FIPS-197 vector, backpressure, reset abort,
// start-while-busy, back-to-back starts, all-zero keys and random round trips.
module tb_aes256_key_unexpand;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] last_keys = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;
  logic [255:0] cipher_key;

  aes256_key_unexpand #(.NUM_ROUNDS(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .last_keys  (last_keys),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_idx     (rk_idx),
    .busy       (busy),
    .done       (done),
    .cipher_key (cipher_key)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] FIPS_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] FIPS_RK13 = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
  localparam logic [127:0] FIPS_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_RK0  = 128'h000102030405060708090a0b0c0d0e0f;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  rc_tb [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
  logic [31:0] mw [60];

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_byte(x[31:24]), sbox_byte(x[23:16]), sbox_byte(x[15:8]), sbox_byte(x[7:0])};
  endfunction

  function automatic logic [31:0] fmix(input int i, input logic [31:0] x);
    if (i % 8 == 0)      return subw({x[23:0], x[31:24]}) ^ {rc_tb[i/8], 24'h0};
    else if (i % 8 == 4) return subw(x);
    else                 return x;
  endfunction

  task automatic model_fwd(input logic [255:0] key);
    for (int k = 0; k < 8; k++) mw[k] = key[255-32*k -: 32];
    for (int i = 8; i < 60; i++) mw[i] = mw[i-8] ^ fmix(i, mw[i-1]);
  endtask

  task automatic model_bwd(input logic [255:0] lk);
    for (int k = 0; k < 8; k++) mw[52+k] = lk[255-32*k -: 32];
    for (int i = 59; i >= 8; i--) mw[i-8] = mw[i] ^ fmix(i, mw[i-1]);
  endtask

  function automatic logic [255:0] model_lk();
    return {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]};
  endfunction

  function automatic logic [255:0] model_key();
    return {mw[0], mw[1], mw[2], mw[3], mw[4], mw[5], mw[6], mw[7]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [131:0] exp_q [$];
  logic [255:0] ck_q [$];
  int           dn_q [$];

  task automatic push_expect(input logic [255:0] ck, input bit timed, input bit fips);
    for (int r = 14; r >= 0; r--) begin
      logic [127:0] d;
      d = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      if (fips) begin
        if (r == 14) d = FIPS_RK14;
        if (r == 13) d = FIPS_RK13;
        if (r == 1)  d = FIPS_RK1;
        if (r == 0)  d = FIPS_RK0;
      end
      exp_q.push_back({4'(r), d});
    end
    ck_q.push_back(ck);
    dn_q.push_back(timed ? cyc + 56 : -1);
  endtask

  // ---------------- monitor ----------------
  int           beat_cnt = 0;
  int           done_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [131:0] prev_beat = '0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 256'(rk_valid), 256'(1));
        check("hold_beat", 256'({rk_idx, rk_data}), 256'(prev_beat));
      end
      prev_stall = rk_valid && !rk_ready;
      prev_beat  = {rk_idx, rk_data};
      if (rk_valid && rk_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat_extra: got idx %0d data %h, expected no beat", rk_idx, rk_data);
        end else begin
          check("beat", 256'({rk_idx, rk_data}), 256'(exp_q.pop_front()));
        end
      end
      if (done) begin
        int t;
        done_cnt++;
        check("busy_at_done", 256'(busy), 256'(0));
        check("beats_left_at_done", 256'(exp_q.size()), 256'(0));
        if (ck_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_extra: got done with key %h, expected no done", cipher_key);
        end else begin
          check("cipher_key", cipher_key, ck_q.pop_front());
        end
        if (dn_q.size() > 0) begin
          t = dn_q.pop_front();
          if (t >= 0) check("done_cycle", 256'(cyc), 256'(t));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  int rdy_mode = 0;

  initial forever begin
    @(posedge clk);
    #2;
    rk_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    ck_q.delete();
    dn_q.delete();
  endtask

  // Caller is positioned just after a negedge; start is seen on the next posedge.
  task automatic issue(input logic [255:0] lk, input logic [255:0] ck, input bit timed, input bit fips);
    push_expect(ck, timed, fips);
    last_keys = lk;
    start     = 1'b1;
    sync();
    start     = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 3000; k++) begin
      sync();
      if (done_cnt != d0) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL done_timeout: got no done in 3000 cycles, expected done");
    rst_n = 1'b0;
    flush();
    sync();
    rst_n = 1'b1;
    sync();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rk_valid"}, 256'(rk_valid), 256'(0));
    check({tag, "_rk_data"}, 256'(rk_data), 256'(0));
    check({tag, "_rk_idx"}, 256'(rk_idx), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_cipher_key"}, cipher_key, 256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] key;
    int b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    sync();
    rst_n = 1'b1;
    sync();

    // FIPS-197 C.3, ready held high, exact done timing
    model_fwd(FIPS_KEY);
    rdy_mode = 0;
    issue({FIPS_RK13, FIPS_RK14}, FIPS_KEY, 1'b1, 1'b1);
    wait_done();

    // same vector under random backpressure
    rdy_mode = 1;
    sync();
    issue({FIPS_RK13, FIPS_RK14}, FIPS_KEY, 1'b0, 1'b1);
    wait_done();

    // start pulses while busy are ignored, then a back-to-back start
    rdy_mode = 0;
    sync();
    issue({FIPS_RK13, FIPS_RK14}, FIPS_KEY, 1'b1, 1'b1);
    repeat (3) sync();
    last_keys = ~last_keys;
    start = 1'b1;
    sync();
    start = 1'b0;
    repeat (25) sync();
    start = 1'b1;
    sync();
    start = 1'b0;
    wait_done();
    issue({FIPS_RK13, FIPS_RK14}, FIPS_KEY, 1'b1, 1'b1);
    wait_done();

    // asynchronous reset right after the RK9 beat, then a clean rerun
    key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    model_fwd(key);
    sync();
    b0 = beat_cnt;
    issue(model_lk(), key, 1'b1, 1'b0);
    for (int k = 0; k < 200 && beat_cnt < b0 + 6; k++) sync();
    check("beats_before_reset", 256'(beat_cnt - b0), 256'(6));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    flush();
    sync();
    rst_n = 1'b1;
    sync();
    issue(model_lk(), key, 1'b1, 1'b0);
    wait_done();

    // all-zero final round keys exercise every Rcon entry from a known start
    model_bwd('0);
    sync();
    issue('0, model_key(), 1'b1, 1'b0);
    wait_done();

    // random round trips, alternating backpressure
    for (int n = 0; n < 100; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      model_fwd(key);
      rdy_mode = n % 2;
      sync();
      issue(model_lk(), key, rdy_mode == 0, 1'b0);
      wait_done();
    end

    repeat (5) sync();
    check("final_queue_empty", 256'(exp_q.size() + ck_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
